// File: rtl/estacao_reserva_add.sv
// Three-entry reservation station feeding a single add/sub unit.
// Captures operands from the common data bus, dispatches one ready entry at a time.
module estacao_reserva_add #(
  parameter logic [3:0] TAG_BASE = 4'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_op,
  input  logic [3:0] issue_vj,
  input  logic [3:0] issue_vk,
  input  logic [3:0] issue_qj,
  input  logic [3:0] issue_qk,
  input  logic       cdb_valid,
  input  logic [3:0] cdb_tag,
  input  logic [3:0] cdb_dado,
  input  logic       unit_done,
  input  logic [3:0] unit_tag,
  output logic       cheio,
  output logic       issue_ack,
  output logic [3:0] issue_tag,
  output logic       exec,
  output logic [3:0] dataa,
  output logic [3:0] datab,
  output logic       op,
  output logic [3:0] tag_out
);

  // Issue handshake: an instruction is accepted on the edge where issue_valid=1
  // and cheio=0; issue_ack/issue_tag report that acceptance for one cycle after.
  // A dropped instruction leaves all state (including issue_tag) untouched.

  logic [2:0] busy_q, busy_d, disp_q, disp_d, ope_q, ope_d;
  logic [3:0] vj_q [3];
  logic [3:0] vj_d [3];
  logic [3:0] qj_q [3];
  logic [3:0] qj_d [3];
  logic [3:0] vk_q [3];
  logic [3:0] vk_d [3];
  logic [3:0] qk_q [3];
  logic [3:0] qk_d [3];

  logic       exec_q, exec_d, op_q, op_d, issue_ack_q, issue_ack_d;
  logic [3:0] dataa_q, dataa_d, datab_q, datab_d, tag_out_q, tag_out_d;
  logic [3:0] issue_tag_q, issue_tag_d;
  logic [1:0] infl_q, infl_d;

  logic [2:0] ready;
  logic       disp_found, free_found, byp_j, byp_k, cdb_hit;
  logic [1:0] disp_sel, free_sel;

  assign cheio = &busy_q;

  always_comb begin
    busy_d      = busy_q;
    disp_d      = disp_q;
    ope_d       = ope_q;
    vj_d        = vj_q;
    qj_d        = qj_q;
    vk_d        = vk_q;
    qk_d        = qk_q;
    exec_d      = exec_q;
    dataa_d     = dataa_q;
    datab_d     = datab_q;
    op_d        = op_q;
    tag_out_d   = tag_out_q;
    infl_d      = infl_q;
    issue_ack_d = 1'b0;
    issue_tag_d = issue_tag_q;
    ready       = '0;
    disp_found  = 1'b0;
    disp_sel    = '0;
    free_found  = 1'b0;
    free_sel    = '0;
    cdb_hit     = cdb_valid && (cdb_tag != 4'd0);
    byp_j       = cdb_hit && (issue_qj == cdb_tag);
    byp_k       = cdb_hit && (issue_qk == cdb_tag);

    // Priority pick from registered state only, so a freshly captured operand
    // waits one edge before its entry becomes dispatchable.
    for (int i = 2; i >= 0; i--) begin
      ready[i] = busy_q[i] && !disp_q[i] && (qj_q[i] == 4'd0) && (qk_q[i] == 4'd0);
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_sel   = 2'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_sel   = 2'(i);
      end
    end

    if (exec_q && unit_done && (unit_tag == tag_out_q)) begin
      busy_d[infl_q] = 1'b0;
      disp_d[infl_q] = 1'b0;
      exec_d         = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      if (busy_q[i] && cdb_hit) begin
        if (qj_q[i] == cdb_tag) begin
          vj_d[i] = cdb_dado;
          qj_d[i] = 4'd0;
        end
        if (qk_q[i] == cdb_tag) begin
          vk_d[i] = cdb_dado;
          qk_d[i] = 4'd0;
        end
      end
    end

    if (!exec_q && disp_found) begin
      exec_d           = 1'b1;
      dataa_d          = vj_q[disp_sel];
      datab_d          = vk_q[disp_sel];
      op_d             = ope_q[disp_sel];
      tag_out_d        = TAG_BASE + {2'b00, disp_sel};
      disp_d[disp_sel] = 1'b1;
      infl_d           = disp_sel;
    end

    if (issue_valid && !cheio && free_found) begin
      busy_d[free_sel] = 1'b1;
      disp_d[free_sel] = 1'b0;
      ope_d[free_sel]  = issue_op;
      vj_d[free_sel]   = byp_j ? cdb_dado : issue_vj;
      qj_d[free_sel]   = byp_j ? 4'd0 : issue_qj;
      vk_d[free_sel]   = byp_k ? cdb_dado : issue_vk;
      qk_d[free_sel]   = byp_k ? 4'd0 : issue_qk;
      issue_ack_d      = 1'b1;
      issue_tag_d      = TAG_BASE + {2'b00, free_sel};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      disp_q      <= '0;
      ope_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        vj_q[i] <= '0;
        qj_q[i] <= '0;
        vk_q[i] <= '0;
        qk_q[i] <= '0;
      end
      exec_q      <= 1'b0;
      dataa_q     <= '0;
      datab_q     <= '0;
      op_q        <= 1'b0;
      tag_out_q   <= '0;
      infl_q      <= '0;
      issue_ack_q <= 1'b0;
      issue_tag_q <= '0;
    end else begin
      busy_q      <= busy_d;
      disp_q      <= disp_d;
      ope_q       <= ope_d;
      vj_q        <= vj_d;
      qj_q        <= qj_d;
      vk_q        <= vk_d;
      qk_q        <= qk_d;
      exec_q      <= exec_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      op_q        <= op_d;
      tag_out_q   <= tag_out_d;
      infl_q      <= infl_d;
      issue_ack_q <= issue_ack_d;
      issue_tag_q <= issue_tag_d;
    end
  end

  assign issue_ack = issue_ack_q;
  assign issue_tag = issue_tag_q;
  assign exec      = exec_q;
  assign dataa     = dataa_q;
  assign datab     = datab_q;
  assign op        = op_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Directed and randomized checks of estacao_reserva_add against a
// transaction-level model of the station's entries.
module tb_estacao_reserva_add;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid, issue_op, cdb_valid, unit_done;
  logic [3:0] issue_vj, issue_vk, issue_qj, issue_qk, cdb_tag, cdb_dado, unit_tag;
  logic       cheio, issue_ack, exec, op;
  logic [3:0] issue_tag, dataa, datab, tag_out;

  estacao_reserva_add #(.TAG_BASE(4'd1)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_dado(cdb_dado),
    .unit_done(unit_done), .unit_tag(unit_tag),
    .cheio(cheio), .issue_ack(issue_ack), .issue_tag(issue_tag),
    .exec(exec), .dataa(dataa), .datab(datab), .op(op), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       busy;
    bit       disp;
    bit       op;
    bit [3:0] vj, qj, vk, qk;
  } ent_t;

  ent_t     m_ent [3];
  bit       m_exec, m_op, m_ack;
  bit [3:0] m_a, m_b, m_tag, m_itag;
  int       m_infl;
  int       n_assert = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_ent[i] = '{default: 0};
    m_exec = 0; m_op = 0; m_ack = 0; m_a = 0; m_b = 0; m_tag = 0; m_itag = 0; m_infl = 0;
  endfunction

  // One clock edge of station behaviour, from the rules for issue, capture,
  // dispatch and completion applied to the state before the edge.
  function automatic void model_step();
    ent_t     nx [3];
    bit       full;
    bit       n_exec;
    bit [3:0] n_tag;
    nx     = m_ent;
    full   = m_ent[0].busy && m_ent[1].busy && m_ent[2].busy;
    n_exec = m_exec;
    n_tag  = m_tag;
    m_ack  = 0;
    if (m_exec && unit_done && unit_tag == m_tag) begin
      nx[m_infl].busy = 0;
      nx[m_infl].disp = 0;
      n_exec = 0;
    end
    if (cdb_valid && cdb_tag != 0) begin
      foreach (m_ent[i]) begin
        if (m_ent[i].busy && m_ent[i].qj == cdb_tag) begin nx[i].vj = cdb_dado; nx[i].qj = 0; end
        if (m_ent[i].busy && m_ent[i].qk == cdb_tag) begin nx[i].vk = cdb_dado; nx[i].qk = 0; end
      end
    end
    if (!m_exec) begin
      for (int i = 0; i < 3; i++) begin
        if (m_ent[i].busy && !m_ent[i].disp && m_ent[i].qj == 0 && m_ent[i].qk == 0) begin
          n_exec = 1; m_a = m_ent[i].vj; m_b = m_ent[i].vk; m_op = m_ent[i].op;
          n_tag = 4'(i + 1); nx[i].disp = 1; m_infl = i;
          break;
        end
      end
    end
    if (issue_valid && !full) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_ent[i].busy) begin
          nx[i].busy = 1; nx[i].disp = 0; nx[i].op = issue_op;
          if (cdb_valid && cdb_tag != 0 && issue_qj == cdb_tag) begin nx[i].vj = cdb_dado; nx[i].qj = 0; end
          else begin nx[i].vj = issue_vj; nx[i].qj = issue_qj; end
          if (cdb_valid && cdb_tag != 0 && issue_qk == cdb_tag) begin nx[i].vk = cdb_dado; nx[i].qk = 0; end
          else begin nx[i].vk = issue_vk; nx[i].qk = issue_qk; end
          m_ack = 1; m_itag = 4'(i + 1);
          break;
        end
      end
    end
    m_ent  = nx;
    m_exec = n_exec;
    m_tag  = n_tag;
  endfunction

  task automatic compare_all(input string pfx);
    check({pfx, ".cheio"}, cheio, m_ent[0].busy && m_ent[1].busy && m_ent[2].busy);
    check({pfx, ".issue_ack"}, issue_ack, m_ack);
    check({pfx, ".issue_tag"}, issue_tag, m_itag);
    check({pfx, ".exec"}, exec, m_exec);
    if (m_exec) begin
      check({pfx, ".dataa"}, dataa, m_a);
      check({pfx, ".datab"}, datab, m_b);
      check({pfx, ".op"}, op, m_op);
      check({pfx, ".tag_out"}, tag_out, m_tag);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_dado = 0; unit_done = 0; unit_tag = 0;
  endtask

  task automatic drive_issue(input bit o, input bit [3:0] vj, qj, vk, qk);
    issue_valid = 1; issue_op = o; issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic drive_cdb(input bit [3:0] t, input bit [3:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_dado = d;
  endtask

  task automatic drive_done(input bit [3:0] t);
    unit_done = 1; unit_tag = t;
  endtask

  task automatic cycle(input string pfx);
    model_step();
    @(posedge clock);
    #1;
    compare_all(pfx);
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst.cheio", cheio, 0);
    check("rst.issue_ack", issue_ack, 0);
    check("rst.issue_tag", issue_tag, 0);
    check("rst.exec", exec, 0);
    check("rst.dataa", dataa, 0);
    check("rst.datab", datab, 0);
    check("rst.op", op, 0);
    check("rst.tag_out", tag_out, 0);
    reset = 0;

    // single add: issue, dispatch, complete
    drive_issue(0, 4'd3, 4'd0, 4'd4, 4'd0);
    cycle("add.issue");
    check("add.ack", issue_ack, 1);
    check("add.tag", issue_tag, 1);
    cycle("add.disp");
    check("add.exec", exec, 1);
    check("add.dataa", dataa, 3);
    check("add.datab", datab, 4);
    check("add.op", op, 0);
    check("add.tag_out", tag_out, 1);
    drive_done(4'd1);
    cycle("add.done");
    check("add.exec_clr", exec, 0);
    check("add.cheio", cheio, 0);

    // fill with waiting ops, then overflow
    for (int i = 0; i < 3; i++) begin
      drive_issue(1'(i), 4'(i), 4'd9, 4'(i + 5), 4'd0);
      cycle("fill");
      check("fill.tag", issue_tag, 4'(i + 1));
    end
    check("fill.cheio", cheio, 1);
    check("fill.exec", exec, 0);
    drive_issue(0, 4'd1, 4'd0, 4'd1, 4'd0);
    cycle("over");
    check("over.ack", issue_ack, 0);
    check("over.tag_kept", issue_tag, 3);
    check("over.exec", exec, 0);

    // broadcast wakes all three; dispatch order by entry
    drive_cdb(4'd9, 4'd7);
    cycle("wake.cap");
    check("wake.exec_late", exec, 0);
    cycle("wake.disp1");
    check("wake.tag1", tag_out, 1);
    check("wake.a1", dataa, 7);
    cycle("wake.hold");
    check("wake.hold_tag", tag_out, 1);
    drive_done(4'd2);
    cycle("wake.bad_done");
    check("wake.ignore", exec, 1);
    drive_done(4'd1);
    cycle("wake.done1");
    check("wake.gap", exec, 0);
    cycle("wake.disp2");
    check("wake.tag2", tag_out, 2);
    check("wake.a2", dataa, 7);
    check("wake.b2", datab, 6);
    check("wake.op2", op, 1);

    // issue with same-cycle bypass on qk
    do_reset();
    drive_issue(0, 4'd1, 4'd0, 4'd0, 4'd5);
    drive_cdb(4'd5, 4'd2);
    cycle("byp.issue");
    cycle("byp.disp");
    check("byp.exec", exec, 1);
    check("byp.datab", datab, 2);

    // full station: completion alongside a dropped issue
    do_reset();
    drive_issue(0, 4'd1, 4'd0, 4'd1, 4'd0);
    cycle("full.a");
    drive_issue(0, 4'd2, 4'd0, 4'd2, 4'd0);
    cycle("full.b");
    drive_issue(0, 4'd3, 4'd9, 4'd3, 4'd0);
    cycle("full.c");
    drive_done(4'd1);
    cycle("full.done1");
    drive_issue(1, 4'd4, 4'd9, 4'd4, 4'd0);
    cycle("full.d");
    check("full.d_tag", issue_tag, 1);
    check("full.inflight", tag_out, 2);
    check("full.cheio", cheio, 1);
    drive_done(4'd2);
    drive_issue(0, 4'd5, 4'd0, 4'd5, 4'd0);
    cycle("full.drop");
    check("full.drop_ack", issue_ack, 0);
    drive_issue(0, 4'd5, 4'd0, 4'd5, 4'd0);
    cycle("full.reuse");
    check("full.reuse_ack", issue_ack, 1);
    check("full.reuse_tag", issue_tag, 2);

    // asynchronous reset while executing
    do_reset();
    drive_issue(1, 4'd6, 4'd0, 4'd2, 4'd0);
    cycle("ar.issue");
    cycle("ar.disp");
    check("ar.exec_pre", exec, 1);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("ar.exec", exec, 0);
    check("ar.dataa", dataa, 0);
    check("ar.tag_out", tag_out, 0);
    check("ar.issue_tag", issue_tag, 0);
    check("ar.cheio", cheio, 0);
    @(posedge clock);
    #1;
    reset = 0;
    drive_done(4'd1);
    cycle("ar.stale");
    check("ar.stale_exec", exec, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        drive_issue(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 7)) & {4{$urandom_range(0, 1) == 1}},
                    4'($urandom), 4'($urandom_range(0, 7)) & {4{$urandom_range(0, 1) == 1}});
      if ($urandom_range(0, 2) == 0) drive_cdb(4'($urandom_range(0, 7)), 4'($urandom));
      if (m_exec && $urandom_range(0, 2) == 0) drive_done(m_tag);
      else if ($urandom_range(0, 5) == 0) drive_done(4'($urandom_range(0, 4)));
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
